// File: rtl/reg_file_pkg.sv
// Shared types and default sizing for the context-switching register file.
package reg_file_pkg;

  localparam int unsigned DEF_W       = 8;
  localparam int unsigned DEF_A       = 4;
  localparam bit          DEF_R0_ZERO = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAVE    = 2'd1,
    RESTORE = 2'd2
  } ctx_state_t;

endpackage

// File: rtl/reg_ctx_seq.sv
// Save/restore sequencer: walks the copy index 0..NREG-1 once per accepted
// request and reports direction, busy and a one-cycle done pulse.
module reg_ctx_seq
  import reg_file_pkg::*;
#(
  parameter int unsigned A = DEF_A
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_save_req,
  input  logic         i_restore_req,
  output logic [A-1:0] o_idx,
  output logic         o_restore,
  output logic         o_busy,
  output logic         o_done
);

  localparam int unsigned NREG = 1 << A;
  // One spare bit keeps the terminal compare free of wrap-around aliasing.
  localparam logic [A:0]  LAST = (A+1)'(NREG - 1);

  ctx_state_t r_state;
  logic [A:0] r_idx;
  logic       r_restore;
  logic       r_busy;
  logic       r_done;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_restore <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_save_req) begin
            r_state   <= SAVE;
            r_restore <= 1'b0;
            r_busy    <= 1'b1;
            r_idx     <= '0;
          end else if (i_restore_req) begin
            r_state   <= RESTORE;
            r_restore <= 1'b1;
            r_busy    <= 1'b1;
            r_idx     <= '0;
          end
        end
        SAVE, RESTORE: begin
          if (r_idx == LAST) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_idx   <= '0;
          end else begin
            r_idx <= r_idx + (A+1)'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_idx     = r_idx[A-1:0];
  assign o_restore = r_restore;
  assign o_busy    = r_busy;
  assign o_done    = r_done;

endmodule

// File: rtl/reg_file_ctx.sv
// Dual-read register file with word/bit writes and a shadow bank for context
// save/restore. Define REG_FILE_CTX_BYPASS_EN to forward word writes to reads.
module reg_file_ctx
  import reg_file_pkg::*;
#(
  parameter int unsigned W       = DEF_W,
  parameter int unsigned A       = DEF_A,
  parameter bit          R0_ZERO = DEF_R0_ZERO
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 WriteEn,
  input  logic                 WriteBitEn,
  input  logic [$clog2(W)-1:0] BitIdx,
  input  logic                 BitValIn,
  input  logic [A-1:0]         Waddr,
  input  logic [W-1:0]         DataIn,
  input  logic [A-1:0]         RaddrA,
  input  logic [A-1:0]         RaddrB,
  output logic [W-1:0]         DataOutA,
  output logic [W-1:0]         DataOutB,
  input  logic                 SaveReq,
  input  logic                 RestoreReq,
  output logic                 Busy,
  output logic                 Done
);

  localparam int unsigned NREG = 1 << A;

  logic [W-1:0] r_regs   [NREG];
  logic [W-1:0] r_shadow [NREG];

  logic [A-1:0] w_idx;
  logic         w_restore;
  logic         w_busy;
  logic         w_done;
  logic         w_bit_ok;
  logic [W-1:0] w_rd_a;
  logic [W-1:0] w_rd_b;

  reg_ctx_seq #(.A(A)) u_seq (
    .i_clk         (Clk),
    .i_reset       (Reset),
    .i_save_req    (SaveReq),
    .i_restore_req (RestoreReq),
    .o_idx         (w_idx),
    .o_restore     (w_restore),
    .o_busy        (w_busy),
    .o_done        (w_done)
  );

  // Bit positions past the word width are silently dropped.
  assign w_bit_ok = WriteBitEn && (32'(BitIdx) < W);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int unsigned i = 0; i < NREG; i++) r_regs[A'(i)] <= '0;
    end else if (w_busy) begin
      if (w_restore) r_regs[w_idx] <= r_shadow[w_idx];
    end else if (WriteEn) begin
      r_regs[Waddr] <= DataIn;
    end else if (w_bit_ok) begin
      r_regs[Waddr][BitIdx] <= BitValIn;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int unsigned i = 0; i < NREG; i++) r_shadow[A'(i)] <= '0;
    end else if (w_busy && !w_restore) begin
      r_shadow[w_idx] <= r_regs[w_idx];
    end
  end

`ifdef REG_FILE_CTX_BYPASS_EN
  logic w_fwd;
  assign w_fwd = WriteEn && !w_busy && !Reset;
`endif

  always_comb begin
    w_rd_a = r_regs[RaddrA];
    w_rd_b = r_regs[RaddrB];
`ifdef REG_FILE_CTX_BYPASS_EN
    if (w_fwd && (RaddrA == Waddr)) w_rd_a = DataIn;
    if (w_fwd && (RaddrB == Waddr)) w_rd_b = DataIn;
`endif
    if (R0_ZERO && (RaddrA == '0)) w_rd_a = '0;
    if (R0_ZERO && (RaddrB == '0)) w_rd_b = '0;
  end

  assign DataOutA = w_rd_a;
  assign DataOutB = w_rd_b;
  assign Busy     = w_busy;
  assign Done     = w_done;

endmodule

// File: tb/tb_reg_file_ctx.sv
// Self-checking bench for reg_file_ctx: array-level reference model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_reg_file_ctx;

  logic       Clk = 1'b0;
  logic       Reset, WriteEn, WriteBitEn, BitValIn, SaveReq, RestoreReq;
  logic [2:0] BitIdx;
  logic [3:0] Waddr, RaddrA, RaddrB;
  logic [7:0] DataIn, DataOutA, DataOutB;
  logic       Busy, Done;

  always #5 Clk = ~Clk;

  reg_file_ctx dut (
    .Clk(Clk), .Reset(Reset), .WriteEn(WriteEn), .WriteBitEn(WriteBitEn),
    .BitIdx(BitIdx), .BitValIn(BitValIn), .Waddr(Waddr), .DataIn(DataIn),
    .RaddrA(RaddrA), .RaddrB(RaddrB), .DataOutA(DataOutA), .DataOutB(DataOutB),
    .SaveReq(SaveReq), .RestoreReq(RestoreReq), .Busy(Busy), .Done(Done)
  );

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Reference: whole-array state, a mode and a count of copy cycles elapsed.
  logic [7:0] m_regs   [16];
  logic [7:0] m_shadow [16];
  int         m_mode;      // 0 idle, 1 save, 2 restore
  logic [4:0] m_cnt;
  logic       m_done;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_rd(input logic [3:0] a);
    logic [7:0] v;
    v = m_regs[a];
`ifdef REG_FILE_CTX_BYPASS_EN
    if (WriteEn && m_mode == 0 && !Reset && a == Waddr) v = DataIn;
`endif
    if (a == 4'd0) v = 8'h00;
    return v;
  endfunction

  always @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < 16; i++) begin
        m_regs[4'(i)]   = 8'h00;
        m_shadow[4'(i)] = 8'h00;
      end
      m_mode = 0;
      m_cnt  = 5'd0;
      m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_mode == 0) begin
        if (WriteEn) m_regs[Waddr] = DataIn;
        else if (WriteBitEn) m_regs[Waddr][BitIdx] = BitValIn;
        if (SaveReq) begin
          m_mode = 1; m_cnt = 5'd0;
        end else if (RestoreReq) begin
          m_mode = 2; m_cnt = 5'd0;
        end
      end else begin
        // Registers are frozen during a save, so the whole snapshot is taken at once.
        if (m_mode == 1 && m_cnt == 5'd0)
          for (int i = 0; i < 16; i++) m_shadow[4'(i)] = m_regs[4'(i)];
        if (m_mode == 2) m_regs[m_cnt[3:0]] = m_shadow[m_cnt[3:0]];
        m_cnt = m_cnt + 5'd1;
        if (m_cnt == 5'd16) begin
          m_mode = 0;
          m_done = 1'b1;
        end
      end
    end
  end

  always @(negedge Clk) begin
    if (chk_en) begin
      chk("cyc_rdA", DataOutA, exp_rd(RaddrA));
      chk("cyc_rdB", DataOutB, exp_rd(RaddrB));
      chk("cyc_busy", 8'(Busy), 8'(m_mode != 0));
      chk("cyc_done", 8'(Done), 8'(m_done));
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    WriteEn = 1'b1; Waddr = a; DataIn = d;
    tick();
    WriteEn = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [3:0] a, input logic [7:0] exp);
    RaddrA = a;
    RaddrB = ~a;
    @(negedge Clk);
    chk(name, DataOutA, exp);
  endtask

  // Counts busy cycles until Busy drops; returns Done as seen in that first idle cycle.
  task automatic wait_done(output int nb, output logic dn);
    nb = 0;
    dn = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge Clk);
      if (Busy) nb++;
      else begin
        dn = Done;
        break;
      end
    end
  endtask

  int   nb;
  logic dn;

  initial begin
    Reset = 1'b1; WriteEn = 1'b0; WriteBitEn = 1'b0; BitIdx = 3'd0; BitValIn = 1'b0;
    Waddr = 4'd0; DataIn = 8'h00; RaddrA = 4'd0; RaddrB = 4'd0;
    SaveReq = 1'b0; RestoreReq = 1'b0;
    tick();
    tick();
    chk_en = 1'b1;
    @(negedge Clk);
    chk("rst_busy", 8'(Busy), 8'h00);
    chk("rst_done", 8'(Done), 8'h00);
    for (int i = 0; i < 16; i++) rd_chk("rst_hold_rd", 4'(i), 8'h00);
    tick();
    Reset = 1'b0;

    // Forwarding of a word write to the same-cycle read.
    WriteEn = 1'b1; Waddr = 4'd7; DataIn = 8'h3C; RaddrA = 4'd7;
    @(negedge Clk);
`ifdef REG_FILE_CTX_BYPASS_EN
    chk("bypass_same", DataOutA, 8'h3C);
`else
    chk("bypass_same", DataOutA, 8'h00);
`endif
    tick();
    WriteEn = 1'b0;
    @(negedge Clk);
    chk("bypass_next", DataOutA, 8'h3C);

    wr(4'd3, 8'hA5);
    RaddrA = 4'd3; RaddrB = 4'd3;
    @(negedge Clk);
    chk("wr_r3_A", DataOutA, 8'hA5);
    chk("wr_r3_B", DataOutB, 8'hA5);
    wr(4'd0, 8'hFF);
    rd_chk("wr_r0_zero", 4'd0, 8'h00);

    wr(4'd5, 8'h00);
    WriteBitEn = 1'b1; Waddr = 4'd5; BitIdx = 3'd6; BitValIn = 1'b1;
    tick();
    WriteBitEn = 1'b0;
    rd_chk("bitwr_r5", 4'd5, 8'h40);
    WriteEn = 1'b1; WriteBitEn = 1'b1; Waddr = 4'd5; DataIn = 8'h11;
    BitIdx = 3'd0; BitValIn = 1'b0;
    tick();
    WriteEn = 1'b0; WriteBitEn = 1'b0;
    rd_chk("word_beats_bit", 4'd5, 8'h11);

    // Context round trip.
    for (int i = 1; i < 16; i++) wr(4'(i), 8'(8'h10 + i));
    SaveReq = 1'b1;
    tick();
    SaveReq = 1'b0;
    wait_done(nb, dn);
    chk("save_busy_len", 8'(nb), 8'd16);
    chk("save_done", 8'(dn), 8'h01);
    for (int i = 0; i < 16; i++) wr(4'(i), 8'h00);
    rd_chk("cleared_r9", 4'd9, 8'h00);
    RestoreReq = 1'b1;
    tick();
    RestoreReq = 1'b0;
    wait_done(nb, dn);
    chk("rest_busy_len", 8'(nb), 8'd16);
    chk("rest_done", 8'(dn), 8'h01);
    for (int i = 1; i < 16; i++) rd_chk("restored", 4'(i), 8'(8'h10 + i));
    rd_chk("restored_r0", 4'd0, 8'h00);

    // Writes and restore requests during a save are dropped.
    SaveReq = 1'b1;
    tick();
    SaveReq = 1'b0;
    WriteEn = 1'b1; Waddr = 4'd2; DataIn = 8'hEE; RestoreReq = 1'b1;
    wait_done(nb, dn);
    WriteEn = 1'b0; RestoreReq = 1'b0;
    chk("busy_ign_len", 8'(nb), 8'd16);
    chk("busy_ign_done", 8'(dn), 8'h01);
    rd_chk("busy_wr_ign", 4'd2, 8'h12);
    chk("busy_rst_ign", 8'(Busy), 8'h00);

    // Simultaneous save+restore must save.
    wr(4'd4, 8'h99);
    SaveReq = 1'b1; RestoreReq = 1'b1;
    tick();
    SaveReq = 1'b0; RestoreReq = 1'b0;
    wait_done(nb, dn);
    chk("both_len", 8'(nb), 8'd16);
    wr(4'd4, 8'h00);
    RestoreReq = 1'b1;
    tick();
    RestoreReq = 1'b0;
    wait_done(nb, dn);
    rd_chk("both_saved", 4'd4, 8'h99);

    // Reset part-way through a restore.
    wr(4'd9, 8'h5A);
    RestoreReq = 1'b1;
    tick();
    RestoreReq = 1'b0;
    repeat (4) tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    @(negedge Clk);
    chk("midrst_busy", 8'(Busy), 8'h00);
    chk("midrst_done", 8'(Done), 8'h00);
    for (int i = 0; i < 16; i++) rd_chk("midrst_rd", 4'(i), 8'h00);
    wr(4'd9, 8'h77);
    RestoreReq = 1'b1;
    tick();
    RestoreReq = 1'b0;
    wait_done(nb, dn);
    chk("zero_rest_len", 8'(nb), 8'd16);
    rd_chk("zero_rest_r9", 4'd9, 8'h00);
    rd_chk("zero_rest_r3", 4'd3, 8'h00);

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

endmodule
